axis_packet_arbiter_rr: RTL and testbench
=========================================

# axis_packet_arbiter_rr

Round-robin, packet-granular arbiter that shares one AXI-Stream output between NUM_INPUTS AXI-Stream requesters. A grant is held from the first beat of a packet until that packet's tlast handshake, so packets are never interleaved. It sits in front of the error-filtering packet FIFOs so that several sources can share one buffered path. The output is registered, which keeps the downstream FIFO write interface off any combinational arbitration path.

## Interface
Parameters:
- NUM_INPUTS, 2: number of requesting streams; must be ≥ 2.
- AXIS_BYTES, 1: tdata width in bytes.
- AXIS_USER_BITS, 1: tuser width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock for all logic.
- sresetn  in  1  synchronous active-low reset.
- axis_i_tvalid  in  NUM_INPUTS  per-input valid.
- axis_i_tready  out  NUM_INPUTS  per-input ready.
- axis_i_tlast  in  NUM_INPUTS  per-input last.
- axis_i_tdata  in  NUM_INPUTS*AXIS_BYTES*8  packed data; input k occupies slice [k*AXIS_BYTES*8 +: AXIS_BYTES*8].
- axis_i_tuser  in  NUM_INPUTS*AXIS_USER_BITS  packed user; input k occupies slice [k*AXIS_USER_BITS +: AXIS_USER_BITS].
- axis_o_tvalid  out  1  output valid.
- axis_o_tready  in  1  output ready.
- axis_o_tlast  out  1  output last.
- axis_o_tdata  out  AXIS_BYTES*8  output data.
- axis_o_tuser  out  AXIS_USER_BITS  output user.
- o_grant  out  NUM_INPUTS  one-hot current grant; all zeros when idle.
- o_busy  out  1  high while in PASS.

## Operation
- State machine with two states: IDLE and PASS.
- Internal registers:
  - g: granted index, width $clog2(NUM_INPUTS).
  - last_g: index of the most recent grant.
  - Output register: valid, data, last and user.
- IDLE:
  - Every axis_i_tready is 0.
  - Priority search starts at (last_g+1) mod NUM_INPUTS and wraps through NUM_INPUTS-1, then 0.
  - The first input with tvalid=1 wins: at the clock edge, g is loaded with its index, o_grant with its one-hot, and the state goes to PASS.
  - If no tvalid is set, the block stays in IDLE.
- PASS:
  - accept = !axis_o_tvalid || axis_o_tready.
  - axis_i_tready[g] = accept; every other tready is 0.
  - A beat transfers when axis_i_tvalid[g] && axis_i_tready[g]. On transfer, the output register loads data, user and last from slice g, and axis_o_tvalid becomes 1.
  - If axis_o_tready=1 and no beat transfers, axis_o_tvalid becomes 0.
  - When the transferred beat has tlast=1: last_g←g, o_grant←0, and the state goes to IDLE.
- Granted tvalid low mid-packet: the grant holds indefinitely and no other input is served.
- Requests from non-granted inputs are ignored until IDLE; they get no tready.
- tdata and tuser are never modified; no beats are dropped or duplicated.

## Timing
- Reset values:
  - State: IDLE.
  - last_g = NUM_INPUTS-1, so input 0 has first priority.
  - g = 0.
  - o_grant = 0, o_busy = 0.
  - axis_o_tvalid = 0, axis_o_tlast = 0, axis_o_tdata = 0, axis_o_tuser = 0.
  - All axis_i_tready = 0.
- Arbitration costs one cycle. tvalid seen in IDLE at edge N gives grant at N+1, and the first beat can be accepted in the cycle after edge N+1.
- Data latency: an input beat accepted at edge M appears on axis_o at M+1.
- Throughput: a packet of L beats with continuous valid/ready occupies L+1 cycles, including the IDLE arbitration cycle. Full throughput within a packet.
- Output backpressure: with axis_o_tvalid=1 and axis_o_tready=0, input tready is 0 and the output holds stable.
- A final beat (tlast) still in the output register while the block is in IDLE is held until axis_o_tready.
- Rotation wraps from index NUM_INPUTS-1 to index 0.
- Simultaneous requests in IDLE are resolved by rotation only; there are no fixed priorities after the first grant.
- Single-beat packet (tlast on the first beat): PASS lasts exactly one accepted beat.
- Reset mid-packet:
  - All state returns to reset values within one cycle.
  - Any partial packet already emitted stays unterminated; downstream relies on its own reset or error drop.

## Test plan
- **Reset:** hold sresetn=0 for 3 cycles with all tvalid=1, then release → during reset axis_o_tvalid=0, o_grant=0 and all tready=0; the first grant after release is o_grant=2'b01.
- **Fairness:** NUM_INPUTS=2, both inputs continuously offer 3-beat packets (input 0 data 0x10..0x12, input 1 data 0x20..0x22), axis_o_tready=1 → output sequence 10,11,12,20,21,22,10,… with tlast on every 3rd beat and one bubble cycle between packets.
- **Wrap-around:** NUM_INPUTS=4, last grant is 3, and inputs 0 and 2 both request → input 0 is granted next.
- **Backpressure:** toggle axis_o_tready 1,0,0,1 during a 4-beat packet → no beat is lost or duplicated, output data is stable while ready=0, and the granted tready mirrors accept.
- **Valid gap:** the granted input drops tvalid for 5 cycles mid-packet while input 1 requests → o_grant is unchanged, input 1 tready=0, and the packet then completes contiguously.
- **Reset mid-packet:** assert sresetn=0 on beat 2 of 4 → the next cycle shows axis_o_tvalid=0 and o_busy=0, and arbitration restarts from input 0.

Source files
------------

// File: rtl/axis_packet_arbiter_rr.sv
// Round-robin AXI-Stream arbiter with packet-granular grants.
// The winning input's beats are forwarded through a registered output stage.
module axis_packet_arbiter_rr #(
  parameter int unsigned NUM_INPUTS     = 2,
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1
) (
  input  logic                                 clk,
  input  logic                                 sresetn,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  output logic                                 axis_o_tvalid,
  input  logic                                 axis_o_tready,
  output logic                                 axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic [NUM_INPUTS-1:0]                o_grant,
  output logic                                 o_busy
);

  localparam int unsigned DW = AXIS_BYTES * 8;
  localparam int unsigned UW = AXIS_USER_BITS;
  localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [IW-1:0]   g;
  logic [IW-1:0]   g_d;
  logic [IW-1:0]   last_g;
  logic [IW-1:0]   last_g_d;
  logic [NUM_INPUTS-1:0] grant_d;
  logic            out_valid_d;
  logic            out_last_d;
  logic [DW-1:0]   out_data_d;
  logic [UW-1:0]   out_user_d;

  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic [UW-1:0]   sel_user;
  logic            found;
  logic [IW-1:0]   winner;
  logic            accept;
  logic            xfer;

  // Granted-input slice selection.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (g == IW'(k)) begin
        sel_valid = axis_i_tvalid[k];
        sel_last  = axis_i_tlast[k];
        sel_data  = axis_i_tdata[k*DW +: DW];
        sel_user  = axis_i_tuser[k*UW +: UW];
      end
    end
  end

  // Rotating priority search starting just after the previous grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= NUM_INPUTS; i++) begin
      if (!found && axis_i_tvalid[IW'((32'(last_g) + i) % NUM_INPUTS)]) begin
        found  = 1'b1;
        winner = IW'((32'(last_g) + i) % NUM_INPUTS);
      end
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d       = state;
    g_d           = g;
    last_g_d      = last_g;
    grant_d       = o_grant;
    out_valid_d   = axis_o_tvalid;
    out_last_d    = axis_o_tlast;
    out_data_d    = axis_o_tdata;
    out_user_d    = axis_o_tuser;
    axis_i_tready = '0;
    accept        = !axis_o_tvalid || axis_o_tready;
    xfer          = 1'b0;

    // A consumed output beat empties the register unless refilled below.
    if (axis_o_tready) begin
      out_valid_d = 1'b0;
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_d = PASS;
          g_d     = winner;
          grant_d = NUM_INPUTS'(1) << winner;
        end
      end
      PASS: begin
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
          if (g == IW'(k)) begin
            axis_i_tready[k] = accept;
          end
        end
        xfer = sel_valid && accept;
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_user_d  = sel_user;
          out_last_d  = sel_last;
          if (sel_last) begin
            last_g_d = g;
            grant_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state         <= IDLE;
      g             <= '0;
      last_g        <= IW'(NUM_INPUTS - 1);
      o_grant       <= '0;
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= '0;
    end else begin
      state         <= state_d;
      g             <= g_d;
      last_g        <= last_g_d;
      o_grant       <= grant_d;
      axis_o_tvalid <= out_valid_d;
      axis_o_tlast  <= out_last_d;
      axis_o_tdata  <= out_data_d;
      axis_o_tuser  <= out_user_d;
    end
  end

  assign o_busy = (state == PASS);

endmodule

// File: tb/tb_axis_packet_arbiter_rr.sv
// Bench for axis_packet_arbiter_rr: packet-level reference model checked every
// cycle, plus directed scenarios with literal expected sequences.
module tb_axis_packet_arbiter_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned UW = 2;

  logic            clk = 1'b0;
  logic            sresetn;
  logic [N-1:0]    i_tvalid;
  logic [N-1:0]    i_tready;
  logic [N-1:0]    i_tlast;
  logic [N*DW-1:0] i_tdata;
  logic [N*UW-1:0] i_tuser;
  logic            o_tvalid;
  logic            o_tready;
  logic            o_tlast;
  logic [DW-1:0]   o_tdata;
  logic [UW-1:0]   o_tuser;
  logic [N-1:0]    o_grant;
  logic            o_busy;

  always #5 clk = ~clk;

  axis_packet_arbiter_rr #(
    .NUM_INPUTS    (N),
    .AXIS_BYTES    (DW / 8),
    .AXIS_USER_BITS(UW)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tready(i_tready),
    .axis_i_tlast (i_tlast),
    .axis_i_tdata (i_tdata),
    .axis_i_tuser (i_tuser),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tready(o_tready),
    .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata),
    .axis_o_tuser (o_tuser),
    .o_grant      (o_grant),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t        src_q [N][$];
  logic [N-1:0] hold;
  int           pops [N];
  int           n_vec = 0;
  int           n_err = 0;
  bit           chk_en = 1'b0;
  int           cyc_n = 0;

  logic [DW-1:0] log_d[$];
  logic          log_l[$];
  int            log_c[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: whoever owns the path, who was served last, and
  // what the single output register holds.
  typedef struct packed {
    logic          busy;
    logic          ov;
    logic          ol;
    logic [DW-1:0] od;
    logic [UW-1:0] ou;
    int            owner;
    int            last;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input logic rstn,
                                        input logic [N-1:0] v, input logic [N-1:0] l,
                                        input logic [N*DW-1:0] d, input logic [N*UW-1:0] u,
                                        input logic rdy);
    model_t n = s;
    logic   room;
    if (!rstn) begin
      n      = '0;
      n.last = N - 1;
      return n;
    end
    room = !s.ov || rdy;
    if (rdy) n.ov = 1'b0;
    if (!s.busy) begin
      for (int i = 1; i <= N; i++) begin
        int c = (s.last + i) % N;
        if (!n.busy && v[c]) begin
          n.busy  = 1'b1;
          n.owner = c;
        end
      end
    end else if (room && v[s.owner]) begin
      n.ov = 1'b1;
      n.od = d[s.owner*DW +: DW];
      n.ou = u[s.owner*UW +: UW];
      n.ol = l[s.owner];
      if (l[s.owner]) begin
        n.busy = 1'b0;
        n.last = s.owner;
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_ready(input model_t s, input logic rdy);
    if (s.busy && (!s.ov || rdy)) return onehot(s.owner);
    return '0;
  endfunction

  always @(posedge clk) m <= model_step(m, sresetn, i_tvalid, i_tlast, i_tdata, i_tuser, o_tready);

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Output handshake log for literal sequence checks.
  always @(posedge clk) begin
    if (sresetn && o_tvalid && o_tready) begin
      log_d.push_back(o_tdata);
      log_l.push_back(o_tlast);
      log_c.push_back(cyc_n);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tready",   32'(i_tready), 32'(exp_ready(m, o_tready)));
      chk("o_tvalid", 32'(o_tvalid), 32'(m.ov));
      chk("o_tlast",  32'(o_tlast),  32'(m.ol));
      chk("o_tdata",  32'(o_tdata),  32'(m.od));
      chk("o_tuser",  32'(o_tuser),  32'(m.ou));
      chk("o_grant",  32'(o_grant),  32'(m.busy ? onehot(m.owner) : '0));
      chk("o_busy",   32'(o_busy),   32'(m.busy));
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        i_tvalid[i]          = 1'b1;
        i_tlast[i]           = src_q[i][0].last;
        i_tdata[i*DW +: DW]  = src_q[i][0].data;
        i_tuser[i*UW +: UW]  = src_q[i][0].user;
      end else begin
        i_tvalid[i]          = 1'b0;
        i_tlast[i]           = 1'b0;
        i_tdata[i*DW +: DW]  = '0;
        i_tuser[i*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (i_tvalid[i] === 1'b1 && i_tready[i] === 1'b1) begin
        void'(src_q[i].pop_front());
        pops[i]++;
      end
    end
    #1;
    drive();
  endtask

  task automatic push_pkt(input int src, input logic [DW-1:0] base, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = base + DW'(b);
      bt.user = UW'(src + b);
      bt.last = (b == len - 1);
      src_q[src].push_back(bt);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting, got expired bound, want completion", name);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((pending() || o_tvalid === 1'b1 || o_busy === 1'b1) && k < 300) begin
      cyc();
      k++;
    end
    if (k >= 300) timeout(name);
  endtask

  task automatic wait_pops(input int src, input int cnt, input string name);
    int p0 = pops[src];
    int k  = 0;
    while (pops[src] - p0 < cnt && k < 100) begin
      cyc();
      k++;
    end
    if (k >= 100) timeout(name);
  endtask

  task automatic clear_logs();
    log_d.delete();
    log_l.delete();
    log_c.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic ex(input logic [DW-1:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic chk_log(input string name);
    int n;
    chk({name, "_count"}, 32'(log_d.size()), 32'(exp_d.size()));
    n = (log_d.size() < exp_d.size()) ? log_d.size() : exp_d.size();
    for (int k = 0; k < n; k++) begin
      chk({name, "_data"}, 32'(log_d[k]), 32'(exp_d[k]));
      chk({name, "_last"}, 32'(log_l[k]), 32'(exp_l[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sresetn  = 1'b0;
    o_tready = 1'b1;
    hold     = '0;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    i_tuser  = '0;
    for (int i = 0; i < N; i++) pops[i] = 0;

    // Reset held with every input requesting.
    for (int i = 0; i < N; i++) push_pkt(i, DW'(8'h01 + i), 1);
    drive();
    cyc();
    chk_en = 1'b1;
    cyc();
    cyc();
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_grant",  32'(o_grant),  32'd0);
    chk("rst_tready", 32'(i_tready), 32'd0);
    clear_logs();
    sresetn = 1'b1;
    cyc();
    chk("first_grant", 32'(o_grant), 32'b0001);
    drain("reset_drain");
    for (int i = 0; i < N; i++) ex(DW'(8'h01 + i), 1'b1);
    chk_log("reset_order");

    // Fairness: inputs 0 and 1 both stream 3-beat packets.
    clear_logs();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 8'h10, 3);
      push_pkt(1, 8'h20, 3);
    end
    drive();
    drain("fair_drain");
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 3; b++) ex(DW'(8'h10 + 16 * s + b), b == 2);
    chk_log("fair");
    if (log_c.size() >= 4) begin
      chk("fair_beat_gap", 32'(log_c[1] - log_c[0]), 32'd1);
      chk("fair_pkt_gap",  32'(log_c[3] - log_c[2]), 32'd2);
      chk("fair_pkt_span", 32'(log_c[3] - log_c[0]), 32'd4);
    end else begin
      chk("fair_log_len", 32'(log_c.size()), 32'd4);
    end

    // Wrap-around from input 3, then rotation without fixed priority.
    push_pkt(3, 8'hB0, 1);
    drive();
    drain("wrap_setup");
    clear_logs();
    push_pkt(0, 8'hA0, 1);
    push_pkt(2, 8'hC0, 1);
    drive();
    cyc();
    chk("wrap_grant", 32'(o_grant), 32'b0001);
    drain("wrap_drain");
    push_pkt(1, 8'hD0, 1);
    push_pkt(3, 8'hE0, 1);
    drive();
    cyc();
    chk("rotate_grant", 32'(o_grant), 32'b1000);
    drain("rotate_drain");
    ex(8'hA0, 1'b1);
    ex(8'hC0, 1'b1);
    ex(8'hE0, 1'b1);
    ex(8'hD0, 1'b1);
    chk_log("wrap");

    // Output backpressure with ready pattern 1,0,0,1.
    clear_logs();
    push_pkt(1, 8'h31, 4);
    drive();
    begin
      int k = 0;
      while ((src_q[1].size() > 0 || o_busy === 1'b1) && k < 100) begin
        o_tready = ((k % 4) == 0) || ((k % 4) == 3);
        cyc();
        k++;
      end
      if (k >= 100) timeout("bp_loop");
    end
    o_tready = 1'b1;
    drain("bp_drain");
    for (int b = 0; b < 4; b++) ex(DW'(8'h31 + b), b == 3);
    chk_log("bp");

    // Granted input stalls mid-packet while input 1 requests.
    clear_logs();
    push_pkt(0, 8'h40, 4);
    drive();
    wait_pops(0, 2, "gap_start");
    hold[0] = 1'b1;
    push_pkt(1, 8'h50, 1);
    drive();
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("gap_grant",   32'(o_grant),     32'b0001);
      chk("gap_tready1", 32'(i_tready[1]), 32'd0);
    end
    hold[0] = 1'b0;
    drive();
    drain("gap_drain");
    for (int b = 0; b < 4; b++) ex(DW'(8'h40 + b), b == 3);
    ex(8'h50, 1'b1);
    chk_log("gap");

    // Reset on beat 2 of a 4-beat packet.
    clear_logs();
    push_pkt(2, 8'h60, 4);
    drive();
    wait_pops(2, 2, "midrst_start");
    sresetn = 1'b0;
    cyc();
    chk("midrst_tvalid", 32'(o_tvalid), 32'd0);
    chk("midrst_busy",   32'(o_busy),   32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    sresetn = 1'b1;
    push_pkt(1, 8'h71, 1);
    push_pkt(0, 8'h70, 1);
    drive();
    cyc();
    chk("restart_grant", 32'(o_grant), 32'b0001);
    drain("restart_drain");
    ex(8'h60, 1'b0);
    ex(8'h70, 1'b1);
    ex(8'h71, 1'b1);
    chk_log("midrst");

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
